// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// spi_ram_pkg: opcodes, FSM states and owner ids shared by the SPI RAM arbiter.
// Revision: 1.0
// ============================================================================
package spi_ram_pkg;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  localparam logic SPI  = 1'b0;
  localparam logic HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    RDWAIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_cmd_buf.sv
`default_nettype none
// ============================================================================
// spi_cmd_buf: decodes SPI words into address latches and a one-entry slot.
// Revision: 1.0
// ============================================================================
module spi_cmd_buf #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_slot_clr,
  output logic                  o_pend_valid,
  output logic                  o_pend_we,
  output logic [ADDR_WIDTH-1:0] o_pend_addr,
  output logic [DATA_WIDTH-1:0] o_pend_wdata,
  output logic                  o_spi_ovf
);
  import spi_ram_pkg::*;

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_we_q, pend_we_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] pend_wdata_q, pend_wdata_d;
  logic                  ovf_q, ovf_d;

  logic [1:0] w_opcode;
  logic [7:0] w_payload;
  logic       w_slot_free;

  assign w_opcode    = i_rx_data[9:8];
  assign w_payload   = i_rx_data[7:0];
  // A slot being granted this edge can take a new post on the same edge.
  assign w_slot_free = !pend_valid_q || i_slot_clr;

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    pend_valid_d = pend_valid_q && !i_slot_clr;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    ovf_d        = ovf_q;
    if (i_rx_valid) begin
      case (w_opcode)
        WR_ADDR: wr_addr_d = ADDR_WIDTH'(w_payload);
        RD_ADDR: rd_addr_d = ADDR_WIDTH'(w_payload);
        WR_DATA: begin
          if (w_slot_free) begin
            pend_valid_d = 1'b1;
            pend_we_d    = 1'b1;
            pend_addr_d  = wr_addr_q;
            pend_wdata_d = DATA_WIDTH'(w_payload);
          end else begin
            ovf_d = 1'b1;
          end
        end
        RD_DATA: begin
          if (w_slot_free) begin
            pend_valid_d = 1'b1;
            pend_we_d    = 1'b0;
            pend_addr_d  = rd_addr_q;
            pend_wdata_d = '0;
          end else begin
            ovf_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      ovf_q        <= ovf_d;
    end
  end

  assign o_pend_valid = pend_valid_q;
  assign o_pend_we    = pend_we_q;
  assign o_pend_addr  = pend_addr_q;
  assign o_pend_wdata = pend_wdata_q;
  assign o_spi_ovf    = ovf_q;

endmodule
`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// spi_ram_arbiter: shares one single-port RAM between SPI commands and a host.
// Define SPI_RAM_ARB_RR_EN for round-robin on ties (default: SPI priority).
// Revision: 1.0
// ============================================================================
module spi_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  spi_ovf
);
  import spi_ram_pkg::*;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_re_q, ram_re_d;
  logic                  owner_q, owner_d;
  logic                  host_gnt_q, host_gnt_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;

  logic                  w_pend_valid;
  logic                  w_pend_we;
  logic [ADDR_WIDTH-1:0] w_pend_addr;
  logic [DATA_WIDTH-1:0] w_pend_wdata;
  logic                  w_slot_clr;
  logic                  w_spi_wins;

  spi_cmd_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmd_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_slot_clr   (w_slot_clr),
    .o_pend_valid (w_pend_valid),
    .o_pend_we    (w_pend_we),
    .o_pend_addr  (w_pend_addr),
    .o_pend_wdata (w_pend_wdata),
    .o_spi_ovf    (spi_ovf)
  );

`ifdef SPI_RAM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // On a tie the requester that did not own the previous access wins.
  assign w_spi_wins = w_pend_valid && (!host_req || (last_owner_q == HOST));

  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_q == IDLE) && (w_pend_valid || host_req)) begin
      last_owner_d = w_spi_wins ? SPI : HOST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= HOST;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign w_spi_wins = w_pend_valid;
`endif

  always_comb begin
    state_d       = state_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_we_d      = 1'b0;
    ram_re_d      = 1'b0;
    owner_d       = owner_q;
    host_gnt_d    = 1'b0;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q && !rx_valid;
    w_slot_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_pend_valid || host_req) begin
          state_d = ACC;
          if (w_spi_wins) begin
            owner_d     = SPI;
            w_slot_clr  = 1'b1;
            ram_addr_d  = w_pend_addr;
            ram_wdata_d = w_pend_wdata;
            ram_we_d    = w_pend_we;
            ram_re_d    = !w_pend_we;
          end else begin
            owner_d     = HOST;
            host_gnt_d  = 1'b1;
            ram_addr_d  = host_addr;
            ram_wdata_d = host_wdata;
            ram_we_d    = host_we;
            ram_re_d    = !host_we;
          end
        end
      end
      ACC: state_d = ram_re_q ? RDWAIT : IDLE;
      RDWAIT: begin
        // Registered RAM read data is valid during this cycle.
        state_d = IDLE;
        if (owner_q == SPI) begin
          tx_data_d  = 8'(ram_rdata);
          tx_valid_d = 1'b1;
        end else begin
          host_rdata_d  = ram_rdata;
          host_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
      ram_re_q      <= 1'b0;
      owner_q       <= HOST;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_we_q      <= ram_we_d;
      ram_re_q      <= ram_re_d;
      owner_q       <= owner_d;
      host_gnt_q    <= host_gnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign ram_re      = ram_re_q;
  assign host_gnt    = host_gnt_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spi_ram_arbiter: directed + randomized checks against a memory model.
// Revision: 1.0
// ============================================================================
module tb_spi_ram_arbiter;

`ifdef SPI_RAM_ARB_RR_EN
  localparam logic EXP_G2_HOST = 1'b1;
`else
  localparam logic EXP_G2_HOST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       ram_re;
  logic [7:0] ram_rdata;
  logic       spi_ovf;

  logic [7:0] mem [256];
  logic       mem_clear;
  logic [7:0] ref_mem [256];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] a, d, hv, ov1, ov2, last_wd;
  logic       got_host, bad;
  int         wcnt;

  spi_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_re      (ram_re),
    .ram_rdata   (ram_rdata),
    .spi_ovf     (spi_ovf)
  );

  always #5 clk = ~clk;

  // Single-port RAM with a registered read port.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic spi_send(input logic [1:0] op, input logic [7:0] pl);
    rx_data  = {op, pl};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_acc(input string tag);
    int n = 0;
    while (!(ram_we || ram_re) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_strobe"}, 32'(ram_we | ram_re), 32'd1);
  endtask

  task automatic spi_write(input logic [7:0] wa, input logic [7:0] wd, input string tag);
    spi_send(2'b00, wa);
    spi_send(2'b01, wd);
    wait_acc(tag);
    check({tag, "_we_re"}, {ram_we, ram_re, host_gnt}, 3'b100);
    check({tag, "_addr"}, ram_addr, wa);
    check({tag, "_wdata"}, ram_wdata, wd);
    ref_mem[wa] = wd;
    tick();
    check({tag, "_we_pulse"}, ram_we, 0);
  endtask

  task automatic spi_read(input logic [7:0] ra, input string tag);
    spi_send(2'b10, ra);
    spi_send(2'b11, 8'($urandom));
    wait_acc(tag);
    check({tag, "_we_re"}, {ram_we, ram_re, host_gnt, tx_valid}, 4'b0100);
    check({tag, "_addr"}, ram_addr, ra);
    tick();
    check({tag, "_rdwait"}, {ram_re, tx_valid}, 2'b00);
    tick();
    check({tag, "_tx"}, {tx_valid, tx_data}, {1'b1, ref_mem[ra]});
    tick();
    check({tag, "_tx_hold"}, {tx_valid, tx_data}, {1'b1, ref_mem[ra]});
  endtask

  task automatic host_write(input logic [7:0] wa, input logic [7:0] wd, input string tag);
    host_req = 1'b1; host_we = 1'b1; host_addr = wa; host_wdata = wd;
    wait_acc(tag);
    check({tag, "_gnt_we"}, {host_gnt, ram_we, ram_re}, 3'b110);
    check({tag, "_addr"}, ram_addr, wa);
    check({tag, "_wdata"}, ram_wdata, wd);
    host_req = 1'b0;
    ref_mem[wa] = wd;
    tick();
    check({tag, "_gnt_pulse"}, {host_gnt, ram_we, host_rvalid}, 3'b000);
  endtask

  task automatic host_read(input logic [7:0] ra, input string tag);
    host_req = 1'b1; host_we = 1'b0; host_addr = ra;
    wait_acc(tag);
    check({tag, "_gnt_re"}, {host_gnt, ram_we, ram_re}, 3'b101);
    check({tag, "_addr"}, ram_addr, ra);
    host_req = 1'b0;
    tick();
    check({tag, "_rdwait"}, {host_gnt, ram_re, host_rvalid}, 3'b000);
    tick();
    check({tag, "_rdata"}, {host_rvalid, host_rdata}, {1'b1, ref_mem[ra]});
    tick();
    check({tag, "_rvalid_pulse"}, host_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_clear = 1'b1;
    rx_data = '0; rx_valid = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    tick(); tick();

    check("rst_ram", {ram_we, ram_re, ram_addr, ram_wdata}, 0);
    check("rst_host", {host_gnt, host_rvalid, host_rdata}, 0);
    check("rst_tx", {tx_valid, tx_data}, 0);
    check("rst_ovf", spi_ovf, 0);

    mem_clear = 1'b0; rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_no_req", {ram_we, ram_re, host_gnt}, 0);

    // Write and read paths through the SPI command stream.
    spi_write(8'h12, 8'hA5, "wr_path");
    spi_read(8'h12, "rd_path");
    tick(); tick();
    check("rd_path_hold_long", {tx_valid, tx_data}, {1'b1, 8'hA5});
    spi_send(2'b00, 8'h77);
    check("rd_path_tx_clear", tx_valid, 0);

    host_write(8'h40, 8'h3C, "host_wr");
    host_read(8'h40, "host_rd");

    // Post on the same edge that the slot is granted: both writes happen.
    d = 8'($urandom); hv = 8'($urandom);
    spi_send(2'b00, 8'h20);
    rx_data = {2'b01, d}; rx_valid = 1'b1;
    tick();
    rx_data = {2'b01, hv};
    tick();
    rx_valid = 1'b0;
    check("same_edge_w1", {ram_we, ram_addr, ram_wdata}, {1'b1, 8'h20, d});
    tick();
    tick();
    check("same_edge_w2", {ram_we, ram_addr, ram_wdata}, {1'b1, 8'h20, hv});
    check("same_edge_no_ovf", spi_ovf, 0);
    ref_mem[8'h20] = hv;
    tick();

    // Contention: host write blocks, then SPI and host request together twice.
    hv = 8'($urandom);
    spi_send(2'b10, 8'h12);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h50; host_wdata = hv;
    wait_acc("cont_blk");
    check("cont_blk_gnt", host_gnt, 1);
    ref_mem[8'h50] = hv;
    host_we = 1'b0; host_addr = 8'h40;
    rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    check("cont_grant1_spi", {host_gnt, ram_re, ram_addr}, {1'b0, 1'b1, 8'h12});
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    check("cont_tx1", {tx_valid, tx_data}, {1'b1, ref_mem[8'h12]});
    tick();
    check("cont_grant2", {host_gnt, ram_re}, {EXP_G2_HOST, 1'b1});
    got_host = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (host_gnt) host_req = 1'b0;
      if (host_rvalid) begin
        got_host = 1'b1;
        check("cont_host_rdata", host_rdata, ref_mem[8'h40]);
      end
      tick();
    end
    check("cont_host_served", {got_host, host_req}, 2'b10);
    check("cont_tx2", {tx_valid, tx_data}, {1'b1, ref_mem[8'h12]});
    check("cont_no_ovf", spi_ovf, 0);

    // Randomized single transactions against the memory model.
    for (int k = 0; k < 24; k++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: spi_write(a, d, "rnd_spi_wr");
        1: spi_read(a, "rnd_spi_rd");
        2: host_write(a, d, "rnd_host_wr");
        default: host_read(a, "rnd_host_rd");
      endcase
    end

    // Overflow: second write word arrives while the slot is still full.
    ov1 = 8'($urandom); ov2 = ~ov1;
    spi_send(2'b00, 8'h30);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    wait_acc("ovf_blk");
    check("ovf_blk_gnt", host_gnt, 1);
    host_req = 1'b0;
    rx_data = {2'b01, ov1}; rx_valid = 1'b1;
    tick();
    check("ovf_not_yet", spi_ovf, 0);
    rx_data = {2'b01, ov2};
    tick();
    rx_valid = 1'b0;
    check("ovf_set", spi_ovf, 1);
    check("ovf_host_rdata", {host_rvalid, host_rdata}, {1'b1, ref_mem[8'h40]});
    wcnt = 0; last_wd = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ram_we) begin
        wcnt++;
        last_wd = ram_wdata;
      end
    end
    check("ovf_one_write", wcnt, 1);
    check("ovf_wdata", last_wd, ov1);
    ref_mem[8'h30] = ov1;
    check("ovf_sticky", spi_ovf, 1);
    spi_read(8'h30, "ovf_rd");
    check("ovf_sticky2", spi_ovf, 1);

    // Reset asserted while a read is in its RAM access cycle.
    spi_send(2'b10, 8'h55);
    spi_send(2'b11, 8'h00);
    wait_acc("rst_acc");
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_strobe", {ram_we, ram_re}, 2'b00);
    check("rst_async_flags", {spi_ovf, tx_valid, host_gnt, host_rvalid}, 4'b0000);
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (tx_valid || host_rvalid || ram_re || ram_we) bad = 1'b1;
    end
    check("rst_no_response", bad, 0);

    a = 8'($urandom); d = 8'($urandom);
    spi_write(a, d, "post_rst_wr");
    host_read(a, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
